// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_seq_ctrl: 3x3 convolution sequencer -- pixel/window tracking, FSM,  |
// | frame-synchronous kernel select. Option: CONV_CTRL_FRAME_STATS_EN.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv_seq_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int BW     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic            in_ready,
  input  logic            enable,
  input  logic [1:0]      kernel_sel,
  output logic [9*BW-1:0] coeffs,
  output logic [3:0]      frac_shift,
  output logic [1:0]      kernel_id,
  output logic [8:0]      col,
  output logic [7:0]      row,
  output logic            window_valid,
  output logic            sof,
  output logic            eof,
  output logic [1:0]      state,
  output logic [15:0]     frame_count
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PIX_W = $clog2(NPIX);
  localparam logic [PIX_W-1:0] PIX_LAST     = PIX_W'(NPIX - 1);
  localparam logic [PIX_W-1:0] PIX_FILL_END = PIX_W'(2 * WIDTH + 2);
  localparam logic [8:0]       COL_LAST     = 9'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [8:0]       ncol_q, ncol_d;   // position of the next pixel to arrive
  logic [7:0]       nrow_q, nrow_d;
  logic [8:0]       col_q, col_d;
  logic [7:0]       row_q, row_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             win_q, win_d;
  logic [1:0]       kernel_q, kernel_d;
  logic             transfer;
  logic             accept;
  logic             last_pix;

  assign in_ready = out_ready;
  assign transfer = in_valid & out_ready;
  assign accept   = transfer & ((state_q != ST_IDLE) | enable);
  assign last_pix = (pix_q == PIX_LAST);

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    ncol_d   = ncol_q;
    nrow_d   = nrow_q;
    col_d    = col_q;
    row_d    = row_q;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    win_d    = win_q;
    kernel_d = kernel_q;

    if (accept) begin
      col_d = ncol_q;
      row_d = nrow_q;
      sof_d = (pix_q == '0);
      eof_d = last_pix;
      // The fill-ending pixel (2,2) is the first full window, so FILL pixels count here too.
      win_d = (ncol_q >= 9'd2) && (nrow_q >= 8'd2);

      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (pix_q == PIX_FILL_END) state_d = ST_RUN;
        default: state_d = state_q;
      endcase

      if (last_pix) begin
        pix_d   = '0;
        ncol_d  = '0;
        nrow_d  = '0;
        state_d = enable ? ST_FILL : ST_IDLE;
      end else begin
        pix_d = pix_q + 1'b1;
        if (ncol_q == COL_LAST) begin
          ncol_d = '0;
          nrow_d = nrow_q + 8'd1;
        end else begin
          ncol_d = ncol_q + 9'd1;
        end
      end
    end

    if ((kernel_sel != 2'd3) && ((state_q == ST_IDLE) || (accept && last_pix)))
      kernel_d = kernel_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pix_q    <= '0;
      ncol_q   <= '0;
      nrow_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      win_q    <= 1'b0;
      kernel_q <= 2'd1;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      ncol_q   <= ncol_d;
      nrow_q   <= nrow_d;
      col_q    <= col_d;
      row_q    <= row_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      win_q    <= win_d;
      kernel_q <= kernel_d;
    end
  end

  assign state        = state_q;
  assign col          = col_q;
  assign row          = row_q;
  assign sof          = sof_q;
  assign eof          = eof_q;
  assign window_valid = win_q;
  assign kernel_id    = kernel_q;

  always_comb begin
    coeffs     = '0;
    frac_shift = (kernel_q == 2'd2) ? 4'd4 : 4'd0;
    for (int n = 0; n < 9; n++) begin
      case (kernel_q)
        2'd0:    coeffs[n*BW +: BW] = (n == 4) ? BW'(1) : BW'(0);
        2'd1:    coeffs[n*BW +: BW] = (n == 4) ? BW'(8) : {BW{1'b1}};
        2'd2:    coeffs[n*BW +: BW] = (n == 4) ? BW'(4) : ((n % 2) == 1) ? BW'(2) : BW'(1);
        default: coeffs[n*BW +: BW] = BW'(0);
      endcase
    end
  end

`ifdef CONV_CTRL_FRAME_STATS_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb fcnt_d = eof_d ? (fcnt_q + 16'd1) : fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_count = fcnt_q;
`else
  assign frame_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_seq_ctrl: randomized bench against a frame-level reference model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_conv_seq_ctrl;

  localparam int W    = 20;
  localparam int H    = 10;
  localparam int BW   = 8;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            enable = 1'b0;
  logic [1:0]      kernel_sel = 2'd1;
  logic            in_ready;
  logic [9*BW-1:0] coeffs;
  logic [3:0]      frac_shift;
  logic [1:0]      kernel_id;
  logic [8:0]      col;
  logic [7:0]      row;
  logic            window_valid, sof, eof;
  logic [1:0]      state;
  logic [15:0]     frame_count;

  conv_seq_ctrl #(.WIDTH(W), .HEIGHT(H), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .in_ready(in_ready), .enable(enable), .kernel_sel(kernel_sel),
    .coeffs(coeffs), .frac_shift(frac_shift), .kernel_id(kernel_id),
    .col(col), .row(row), .window_valid(window_valid), .sof(sof), .eof(eof),
    .state(state), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level model: m_idx is the index of the next pixel of the frame.
  bit m_inframe;
  int m_idx, m_col, m_row, m_kid, m_fc;
  bit m_sof, m_eof, m_win;

  function automatic void model_reset();
    m_inframe = 0; m_idx = 0; m_col = 0; m_row = 0;
    m_sof = 0; m_eof = 0; m_win = 0; m_kid = 1; m_fc = 0;
  endfunction

  function automatic void model_step(input bit v, input bit r, input bit en, input int ks);
    bit acc, latch;
    acc   = v && r && (m_inframe || en);
    latch = !m_inframe || (acc && m_idx == NPIX - 1);
    m_sof = 0;
    m_eof = 0;
    if (acc) begin
      m_col = m_idx % W;
      m_row = m_idx / W;
      m_sof = (m_idx == 0);
      m_eof = (m_idx == NPIX - 1);
      m_win = (m_col >= 2) && (m_row >= 2);
      if (m_eof) begin
        m_fc++;
        m_idx = 0;
        m_inframe = en;
      end else begin
        m_idx++;
        m_inframe = 1;
      end
    end
    if (latch && ks != 3) m_kid = ks;
  endfunction

  function automatic logic [9*BW-1:0] kernel_coeffs(input int k);
    int t [3][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                     '{-1, -1, -1, -1, 8, -1, -1, -1, -1},
                     '{1, 2, 1, 2, 4, 2, 1, 2, 1}};
    logic [9*BW-1:0] c;
    c = '0;
    for (int n = 0; n < 9; n++) c[n*BW +: BW] = BW'(t[k][n]);
    return c;
  endfunction

  function automatic logic [116:0] exp_bundle();
    logic [1:0]  es;
    logic [15:0] efc;
    es = !m_inframe ? 2'd0 : (m_idx > 2 * W + 2) ? 2'd2 : 2'd1;
`ifdef CONV_CTRL_FRAME_STATS_EN
    efc = 16'(m_fc);
`else
    efc = 16'd0;
`endif
    return {out_ready, es, 2'(m_kid), 9'(m_col), 8'(m_row), m_win, m_sof, m_eof,
            efc, (m_kid == 2) ? 4'd4 : 4'd0, kernel_coeffs(m_kid)};
  endfunction

  function automatic logic [116:0] dut_bundle();
    return {in_ready, state, kernel_id, col, row, window_valid, sof, eof,
            frame_count, frac_shift, coeffs};
  endfunction

  task automatic cycle(input bit v, input bit r, input bit en, input int ks);
    in_valid = v; out_ready = r; enable = en; kernel_sel = 2'(ks);
    @(posedge clk);
    model_step(v, r, en, ks);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b1; enable = 1'b1; kernel_sel = 2'd2;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_bundle() !== exp_bundle()) begin
      n_bad++;
      $display("FAIL reset_values: got %h exp %h", dut_bundle(), exp_bundle());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    int wins = 0;
    do_reset();
    cycle(0, 1, 1, 1);
    for (int i = 0; i < NPIX; i++) begin
      cycle(1, 1, 1, 1);
      wins += int'(window_valid);
      n_cmp++;
      if (dut_bundle() !== exp_bundle()) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL full_frame px %0d: got %h exp %h", i, dut_bundle(), exp_bundle());
      end
      if (i == 0) begin
        n_cmp++;
        if (sof !== 1'b1) begin n_bad++; $display("FAIL sof_first: got %b exp 1", sof); end
      end
      if (i == 2 * W + 2) begin
        n_cmp++;
        if (state !== 2'd2) begin n_bad++; $display("FAIL run_entry: got %0d exp 2", state); end
      end
      if (i == NPIX - 1) begin
        n_cmp++;
        if (eof !== 1'b1) begin n_bad++; $display("FAIL eof_last: got %b exp 1", eof); end
      end
    end
    n_cmp++;
    if (wins != (W - 2) * (H - 2)) begin
      n_bad++;
      $display("FAIL window_count: got %0d exp %0d", wins, (W - 2) * (H - 2));
    end
`ifdef CONV_CTRL_FRAME_STATS_EN
    n_cmp++;
    if (frame_count !== 16'd1) begin n_bad++; $display("FAIL frame_count: got %0d exp 1", frame_count); end
`endif
  endtask

  task automatic test_backpressure();
    int prev_lin = 0;
    int lin;
    do_reset();
    for (int i = 0; i < 2 * NPIX + 10; i++) begin
      cycle(1, (i % 2) == 0, 1, 1);
      n_cmp++;
      if (dut_bundle() !== exp_bundle()) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL backpressure cyc %0d: got %h exp %h", i, dut_bundle(), exp_bundle());
      end
      lin = int'(row) * W + int'(col);
      if (i > 1 && lin != prev_lin) begin
        n_cmp++;
        if (lin != (prev_lin + 1) % NPIX) begin
          n_bad++;
          $display("FAIL col_skip: got %0d exp %0d", lin, (prev_lin + 1) % NPIX);
        end
      end
      prev_lin = lin;
    end
  endtask

  task automatic test_kernel_switch();
    int p = 3 * W + 5;
    do_reset();
    cycle(0, 1, 1, 1);
    for (int t = 0; t < 2 * NPIX; t++) begin
      cycle(1, 1, 1, (t < p) ? 1 : (t < NPIX) ? 2 : 3);
      n_cmp++;
      if (dut_bundle() !== exp_bundle()) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL kernel_switch px %0d: got %h exp %h", t, dut_bundle(), exp_bundle());
      end
      if (t == NPIX - 2) begin
        n_cmp++;
        if (kernel_id !== 2'd1) begin n_bad++; $display("FAIL kernel_hold_midframe: got %0d exp 1", kernel_id); end
      end
      if (t == NPIX - 1) begin
        n_cmp++;
        if (coeffs !== 72'h01_02_01_02_04_02_01_02_01 || frac_shift !== 4'd4) begin
          n_bad++;
          $display("FAIL kernel_blur: got %h/%0d exp 010201020402010201/4", coeffs, frac_shift);
        end
      end
      if (t == 2 * NPIX - 1) begin
        n_cmp++;
        if (kernel_id !== 2'd2) begin n_bad++; $display("FAIL kernel_reserved: got %0d exp 2", kernel_id); end
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    for (int t = 0; t < NPIX; t++) begin
      cycle(1, 1, t < 50, 0);
      n_cmp++;
      if (dut_bundle() !== exp_bundle()) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL disable px %0d: got %h exp %h", t, dut_bundle(), exp_bundle());
      end
    end
    n_cmp++;
    if (eof !== 1'b1 || state !== 2'd0) begin
      n_bad++;
      $display("FAIL disable_finish: got eof=%b state=%0d exp eof=1 state=0", eof, state);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom), 1'($urandom), 0, 0);
      n_cmp++;
      if (col !== 9'(W - 1) || row !== 8'(H - 1) || state !== 2'd0) begin
        n_bad++;
        $display("FAIL idle_hold: got col=%0d row=%0d state=%0d exp %0d %0d 0", col, row, state, W - 1, H - 1);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int t = 0; t < 120; t++) cycle(1, 1, 1, 2);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_bundle() !== exp_bundle()) begin
      n_bad++;
      $display("FAIL async_reset: got %h exp %h", dut_bundle(), exp_bundle());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1, 1, 1, 1);
    n_cmp++;
    if (sof !== 1'b1 || col !== 9'd0 || row !== 8'd0 || state !== 2'd1) begin
      n_bad++;
      $display("FAIL restart_px0: got sof=%b col=%0d row=%0d state=%0d exp 1 0 0 1", sof, col, row, state);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3 * NPIX; i++) begin
      cycle(1'($urandom), ($urandom % 4) != 0, ($urandom % 8) != 0, int'($urandom % 4));
      n_cmp++;
      if (dut_bundle() !== exp_bundle()) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL random cyc %0d: got %h exp %h", i, dut_bundle(), exp_bundle());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_kernel_switch();
    test_disable();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
